// File: rtl/arithmetic_fu_pipe.sv
// arithmetic_fu_pipe
//   Pipelined integer ALU functional unit (RV32I/RV64I register-register ops).
//   The result is computed combinationally in front of stage 1. Stages 2..STAGES
//   only carry {valid, result, rob_entry, dest_tag}. A single advance enable
//   moves or freezes the whole pipe, so bubbles are never squeezed out.
//
// Parameters
//   XLEN           operand/result width (32 or 64)
//   ROB_SIZE       ROB entries, tag width $clog2(ROB_SIZE)
//   PHYS_REG_SIZE  physical registers, tag width $clog2(PHYS_REG_SIZE)
//   STAGES         pipeline depth 1..4 (latency in cycles)
//
// Ports
//   clk, rst (async, active-low), flush (kills all in-flight ops)
//   valid_in / ready_in           issue-side handshake
//   additional_info               funct7[5], selects SUB / SRA
//   arithmetic_type               funct3
//   rob_entry_in, dest_tag_in     bookkeeping carried alongside the op
//   rs1, rs2                      operands
//   valid_out / ready_out         CDB-side handshake
//   result, rob_entry, dest_tag   completed op
//
// Optional feature (macro ARITH_FU_PERF_EN)
//   perf_ops    [31:0]  completed output handshakes, wraps
//   perf_stalls [31:0]  cycles with an op in the last stage and ready_out=0, wraps
module arithmetic_fu_pipe #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_SIZE      = 256,
    parameter int unsigned PHYS_REG_SIZE = 256,
    parameter int unsigned STAGES        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic                             additional_info,
    input  logic [2:0]                       arithmetic_type,
    input  logic [$clog2(ROB_SIZE)-1:0]      rob_entry_in,
    input  logic [$clog2(PHYS_REG_SIZE)-1:0] dest_tag_in,
    input  logic [XLEN-1:0]                  rs1,
    input  logic [XLEN-1:0]                  rs2,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [XLEN-1:0]                  result,
    output logic [$clog2(ROB_SIZE)-1:0]      rob_entry,
`ifdef ARITH_FU_PERF_EN
    output logic [$clog2(PHYS_REG_SIZE)-1:0] dest_tag,
    output logic [31:0]                      perf_ops,
    output logic [31:0]                      perf_stalls
`else
    output logic [$clog2(PHYS_REG_SIZE)-1:0] dest_tag
`endif
);

    localparam int unsigned ROB_W = $clog2(ROB_SIZE);
    localparam int unsigned TAG_W = $clog2(PHYS_REG_SIZE);
    localparam int unsigned SH_W  = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SLL  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_XOR  = 3'b100,
        OP_SR   = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } op_e;

    op_e              op;
    logic [SH_W-1:0]  shamt;
    logic [XLEN-1:0]  alu_res;

    logic [STAGES-1:0] vld_q;
    logic [XLEN-1:0]   res_q [STAGES];
    logic [ROB_W-1:0]  rob_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    logic valid_last;
    logic adv;

    assign op    = op_e'(arithmetic_type);
    assign shamt = rs2[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = additional_info ? (rs1 - rs2) : (rs1 + rs2);
            OP_SLL:  alu_res = rs1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            OP_XOR:  alu_res = rs1 ^ rs2;
            OP_SR:   alu_res = additional_info ? $unsigned($signed(rs1) >>> shamt)
                                               : (rs1 >> shamt);
            OP_OR:   alu_res = rs1 | rs2;
            OP_AND:  alu_res = rs1 & rs2;
            default: alu_res = '0;
        endcase
    end

    assign valid_last = vld_q[STAGES-1];
    // The pipe only ever blocks on its last stage; ready_in must not look at
    // valid_in, so it is the advance enable itself.
    assign adv        = !valid_last || ready_out;
    assign ready_in   = adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                rob_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            // Flush only clears valids (even when stalled); data keeps moving
            // with adv so the datapath has no flush dependency.
            if (flush) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q[0] <= valid_in;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
            if (adv) begin
                res_q[0] <= alu_res;
                rob_q[0] <= rob_entry_in;
                tag_q[0] <= dest_tag_in;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    res_q[i] <= res_q[i-1];
                    rob_q[i] <= rob_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    // Masking with flush keeps the CDB from completing a handshake on an op
    // that is being killed on this very edge.
    assign valid_out = valid_last && !flush;
    assign result    = res_q[STAGES-1];
    assign rob_entry = rob_q[STAGES-1];
    assign dest_tag  = tag_q[STAGES-1];

`ifdef ARITH_FU_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops    <= '0;
            perf_stalls <= '0;
        end else begin
            if (valid_out && ready_out) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (valid_last && !ready_out) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arithmetic_fu_pipe.sv
// Testbench for arithmetic_fu_pipe: randomized and directed stimulus checked
// against an in-order scoreboard fed by an arithmetic reference model.
module tb_arithmetic_fu_pipe;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ROB_SIZE      = 256;
    localparam int unsigned PHYS_REG_SIZE = 256;
    localparam int unsigned STAGES        = 2;
    localparam int unsigned ROB_W         = $clog2(ROB_SIZE);
    localparam int unsigned TAG_W         = $clog2(PHYS_REG_SIZE);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             valid_in;
    logic             ready_in;
    logic             additional_info;
    logic [2:0]       arithmetic_type;
    logic [ROB_W-1:0] rob_entry_in;
    logic [TAG_W-1:0] dest_tag_in;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             valid_out;
    logic             ready_out;
    logic [XLEN-1:0]  result;
    logic [ROB_W-1:0] rob_entry;
    logic [TAG_W-1:0] dest_tag;
`ifdef ARITH_FU_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stalls;
`endif

    arithmetic_fu_pipe #(
        .XLEN(XLEN),
        .ROB_SIZE(ROB_SIZE),
        .PHYS_REG_SIZE(PHYS_REG_SIZE),
        .STAGES(STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .additional_info(additional_info),
        .arithmetic_type(arithmetic_type),
        .rob_entry_in(rob_entry_in),
        .dest_tag_in(dest_tag_in),
        .rs1(rs1),
        .rs2(rs2),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .result(result),
        .rob_entry(rob_entry),
`ifdef ARITH_FU_PERF_EN
        .dest_tag(dest_tag),
        .perf_ops(perf_ops),
        .perf_stalls(perf_stalls)
`else
        .dest_tag(dest_tag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } ent_t;

    typedef struct {
        logic [2:0]       op;
        logic             alt;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] tag;
    } op_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    ent_t exp_q[$];   // accepted, not yet seen at the output
    ent_t want_q[$];  // expectation paired with each observed handshake
    ent_t got_q[$];   // observed handshakes
    op_t  pend_q[$];

    // Reference model: plain arithmetic on the opcode rules.
    function automatic logic [XLEN-1:0] ref_alu(input logic [2:0] op, input logic alt,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] msb;
        int unsigned     sh;
        msb = '0;
        msb[XLEN-1] = 1'b1;
        sh = int'(b % XLEN);
        r = '0;
        case (op)
            3'd0: r = alt ? (a + (~b) + 1'b1) : (a + b);
            3'd1: begin r = a; repeat (sh) r = r + r; end
            3'd2: r = {{(XLEN-1){1'b0}}, ((a ^ msb) < (b ^ msb))};
            3'd3: r = {{(XLEN-1){1'b0}}, (a < b)};
            3'd4: r = a ^ b;
            3'd5: begin
                r = a;
                repeat (sh) r = (r / 2) | ((alt && a[XLEN-1]) ? msb : '0);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic op_t rand_op(input int unsigned rob, input int unsigned tag);
        op_t o;
        o.op  = 3'($urandom_range(0, 7));
        o.alt = 1'($urandom_range(0, 1));
        o.a   = XLEN'($urandom);
        o.b   = ($urandom_range(0, 1) == 1) ? XLEN'($urandom) : XLEN'($urandom_range(0, 70));
        o.rob = ROB_W'(rob);
        o.tag = TAG_W'(tag);
        return o;
    endfunction

    function automatic op_t mk(input logic [2:0] op, input logic alt, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input int unsigned rob);
        op_t o;
        o.op = op; o.alt = alt; o.a = a; o.b = b;
        o.rob = ROB_W'(rob);
        o.tag = TAG_W'(rob + 100);
        return o;
    endfunction

    task automatic present(input op_t o);
        valid_in        = 1'b1;
        arithmetic_type = o.op;
        additional_info = o.alt;
        rs1             = o.a;
        rs2             = o.b;
        rob_entry_in    = o.rob;
        dest_tag_in     = o.tag;
    endtask

    // One clock cycle: entered and left at posedge+1. Records handshakes and
    // updates the model; performs no comparisons.
    task automatic tick(output bit acc);
        bit   hs;
        ent_t g;
        ent_t w;
        #1;
        acc = valid_in && ready_in;
        hs  = valid_out && ready_out;
        if (hs) begin
            g.res = result; g.rob = rob_entry; g.tag = dest_tag; g.cyc = cyc;
            got_q.push_back(g);
            if (exp_q.size() > 0) begin
                want_q.push_back(exp_q.pop_front());
            end else begin
                w = g; w.res = ~g.res; w.cyc = -1;
                want_q.push_back(w);
            end
        end
        if (flush) begin
            exp_q.delete();
        end else if (acc) begin
            w.res = ref_alu(arithmetic_type, additional_info, rs1, rs2);
            w.rob = rob_entry_in; w.tag = dest_tag_in; w.cyc = cyc;
            exp_q.push_back(w);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(output bit ok);
        bit acc;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) tick(acc);
        ok = (exp_q.size() == 0);
    endtask

    task automatic clear_sb();
        exp_q.delete(); want_q.delete(); got_q.delete(); pend_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        additional_info = 1'b0; arithmetic_type = '0; rob_entry_in = '0;
        dest_tag_in = '0; rs1 = '0; rs2 = '0;
        #1 rst = 1'b0;
        #10;
        total_cnt += 5;
        if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out); else pass_cnt++;
        if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
        if (rob_entry !== '0) $display("FAIL reset_rob: got %h want 0", rob_entry); else pass_cnt++;
        if (dest_tag !== '0) $display("FAIL reset_tag: got %h want 0", dest_tag); else pass_cnt++;
        if (ready_in !== 1'b1) $display("FAIL reset_ready_in: got %b want 1", ready_in); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        bit acc;
        bit ok;
        int n;
        int nacc;
        clear_sb();
        ready_out = 1'b1;
        pend_q.push_back(mk(3'd0, 1'b0, 32'hFFFF_FFF0, 32'h10, 0));
        pend_q.push_back(mk(3'd0, 1'b1, 32'hFFFF_FFF0, 32'h10, 1));
        pend_q.push_back(mk(3'd2, 1'b0, 32'hFFFF_FFF0, 32'h10, 2));
        pend_q.push_back(mk(3'd3, 1'b0, 32'hFFFF_FFF0, 32'h10, 3));
        pend_q.push_back(mk(3'd1, 1'b0, 32'hFFFF_FFF0, 32'h10, 4));
        pend_q.push_back(mk(3'd5, 1'b1, 32'hFFFF_FFF0, 32'h10, 5));
        pend_q.push_back(mk(3'd5, 1'b0, 32'hFFFF_FFF0, 32'h10, 6));
        pend_q.push_back(mk(3'd4, 1'b0, 32'hFFFF_FFF0, 32'h10, 7));
        pend_q.push_back(mk(3'd6, 1'b0, 32'hFFFF_FFF0, 32'h10, 8));
        pend_q.push_back(mk(3'd7, 1'b0, 32'hFFFF_FFF0, 32'h10, 9));
        pend_q.push_back(mk(3'd1, 1'b0, 32'h1, 32'h21, 10));
        pend_q.push_back(mk(3'd2, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 11));
        pend_q.push_back(mk(3'd3, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 12));
        pend_q.push_back(mk(3'd5, 1'b1, 32'h8000_0000, 32'h1F, 13));
        pend_q.push_back(mk(3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 14));
        for (int i = 0; i < 40; i++) pend_q.push_back(rand_op(20 + i, $urandom_range(0, 255)));
        n = pend_q.size();
        nacc = 0;
        foreach (pend_q[i]) begin
            present(pend_q[i]);
            tick(acc);
            if (acc) nacc++;
        end
        drain(ok);
        total_cnt += 3;
        if (!ok) $display("FAIL ops_drain_timeout: got %0d left want 0", exp_q.size()); else pass_cnt++;
        if (nacc !== n) $display("FAIL ops_throughput: got %0d accepted want %0d", nacc, n); else pass_cnt++;
        if (got_q.size() !== n) $display("FAIL ops_count: got %0d want %0d", got_q.size(), n); else pass_cnt++;
        foreach (got_q[i]) begin
            total_cnt += 2;
            if (got_q[i].res !== want_q[i].res || got_q[i].rob !== want_q[i].rob || got_q[i].tag !== want_q[i].tag)
                $display("FAIL ops_data[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, got_q[i].res, got_q[i].rob,
                         got_q[i].tag, want_q[i].res, want_q[i].rob, want_q[i].tag);
            else pass_cnt++;
            if (got_q[i].cyc - want_q[i].cyc !== STAGES)
                $display("FAIL ops_latency[%0d]: got %0d want %0d", i, got_q[i].cyc - want_q[i].cyc, STAGES);
            else pass_cnt++;
        end
        total_cnt += 3;
        if (got_q[0].res !== 32'h0) $display("FAIL add_wrap: got %h want 00000000", got_q[0].res); else pass_cnt++;
        if (got_q[6].res !== 32'h0000_FFFF) $display("FAIL srl_const: got %h want 0000ffff", got_q[6].res); else pass_cnt++;
        if (got_q[10].res !== 32'h2) $display("FAIL shift_mask: got %h want 00000002", got_q[10].res); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit acc;
        bit ok;
        int nacc;
        logic [XLEN-1:0] r10;
        clear_sb();
        for (int i = 0; i < 4; i++) pend_q.push_back(rand_op(10 + i, 50 + i));
        r10 = ref_alu(pend_q[0].op, pend_q[0].alt, pend_q[0].a, pend_q[0].b);
        ready_out = 1'b0;
        nacc = 0;
        for (int k = 0; k < STAGES + 3; k++) begin
            present(pend_q[0]);
            tick(acc);
            if (acc) begin void'(pend_q.pop_front()); nacc++; end
            if (nacc >= STAGES) begin
                total_cnt += 3;
                if (ready_in !== 1'b0) $display("FAIL bp_ready_in_low: got %b want 0", ready_in); else pass_cnt++;
                if (valid_out !== 1'b1 || rob_entry !== ROB_W'(10))
                    $display("FAIL bp_hold_rob: got %b/%0d want 1/10", valid_out, rob_entry);
                else pass_cnt++;
                if (result !== r10) $display("FAIL bp_hold_result: got %h want %h", result, r10); else pass_cnt++;
            end
        end
        ready_out = 1'b1;
        #1;
        total_cnt++;
        if (ready_in !== 1'b1) $display("FAIL bp_ready_in_rise: got %b want 1", ready_in); else pass_cnt++;
        for (int k = 0; k < 20 && pend_q.size() > 0; k++) begin
            present(pend_q[0]);
            tick(acc);
            if (acc) void'(pend_q.pop_front());
        end
        drain(ok);
        total_cnt += 2;
        if (!ok || pend_q.size() != 0) $display("FAIL bp_drain_timeout: got %0d left want 0", exp_q.size() + pend_q.size()); else pass_cnt++;
        if (got_q.size() !== 4) $display("FAIL bp_count: got %0d want 4", got_q.size()); else pass_cnt++;
        foreach (got_q[i]) begin
            total_cnt++;
            if (got_q[i].rob !== ROB_W'(10 + i) || got_q[i].res !== want_q[i].res || got_q[i].tag !== want_q[i].tag)
                $display("FAIL bp_order[%0d]: got %0d/%h want %0d/%h", i, got_q[i].rob, got_q[i].res, 10 + i, want_q[i].res);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_bp();
        bit acc;
        bit ok;
        bit pv;
        logic [XLEN-1:0]  pres;
        logic [ROB_W-1:0] prob;
        int nacc;
        clear_sb();
        for (int i = 0; i < 40; i++) pend_q.push_back(rand_op(100 + i, $urandom_range(0, 255)));
        nacc = 0;
        for (int k = 0; k < 1000 && pend_q.size() > 0; k++) begin
            present(pend_q[0]);
            valid_in  = ($urandom_range(0, 3) != 0);
            ready_out = 1'($urandom_range(0, 1));
            pv   = valid_out && !ready_out;
            pres = result;
            prob = rob_entry;
            tick(acc);
            if (acc) begin void'(pend_q.pop_front()); nacc++; end
            if (pv) begin
                total_cnt++;
                if (valid_out !== 1'b1 || result !== pres || rob_entry !== prob)
                    $display("FAIL rbp_stable: got %b/%h/%0d want 1/%h/%0d", valid_out, result, rob_entry, pres, prob);
                else pass_cnt++;
            end
        end
        drain(ok);
        total_cnt += 2;
        if (!ok || nacc != 40) $display("FAIL rbp_timeout: got %0d accepted want 40", nacc); else pass_cnt++;
        if (got_q.size() !== 40) $display("FAIL rbp_count: got %0d want 40", got_q.size()); else pass_cnt++;
        foreach (got_q[i]) begin
            total_cnt++;
            if (got_q[i].res !== want_q[i].res || got_q[i].rob !== want_q[i].rob || got_q[i].tag !== want_q[i].tag)
                $display("FAIL rbp_data[%0d]: got %h/%0d want %h/%0d", i, got_q[i].res, got_q[i].rob, want_q[i].res, want_q[i].rob);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        bit acc;
        bit ok;
        clear_sb();
        ready_out = 1'b1;
        present(mk(3'd6, 1'b0, 32'h1234, 32'h1, 30)); tick(acc);
        present(mk(3'd6, 1'b0, 32'h5678, 32'h1, 31)); tick(acc);
        total_cnt++;
        if (valid_out !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", valid_out); else pass_cnt++;
        present(mk(3'd0, 1'b0, 32'h7, 32'h9, 32));
        flush = 1'b1;
        #1;
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL flush_mask: got %b want 0", valid_out); else pass_cnt++;
        tick(acc);
        flush = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < STAGES + 2; k++) begin
            total_cnt++;
            if (valid_out !== 1'b0) $display("FAIL flush_after[%0d]: got %b want 0", k, valid_out); else pass_cnt++;
            tick(acc);
        end
        present(mk(3'd4, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 33)); tick(acc);
        drain(ok);
        total_cnt += 3;
        if (!ok) $display("FAIL flush_drain_timeout: got %0d left want 0", exp_q.size()); else pass_cnt++;
        if (got_q.size() !== 1) $display("FAIL flush_count: got %0d want 1", got_q.size()); else pass_cnt++;
        if (got_q[0].rob !== ROB_W'(33) || got_q[0].res !== 32'hA5A5_5A5A)
            $display("FAIL flush_next_op: got %0d/%h want 33/a5a55a5a", got_q[0].rob, got_q[0].res);
        else pass_cnt++;
    endtask

    task automatic test_flush_stall();
        bit acc;
        bit ok;
        clear_sb();
        ready_out = 1'b0;
        for (int k = 0; k < 10 && ready_in; k++) begin
            present(rand_op(40 + k, k));
            tick(acc);
        end
        total_cnt++;
        if (ready_in !== 1'b0) $display("FAIL fs_full: got %b want 0", ready_in); else pass_cnt++;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        valid_in = 1'b0;
        total_cnt += 2;
        if (ready_in !== 1'b1) $display("FAIL fs_emptied: got %b want 1", ready_in); else pass_cnt++;
        if (valid_out !== 1'b0) $display("FAIL fs_valid: got %b want 0", valid_out); else pass_cnt++;
        drain(ok);
        for (int k = 0; k < STAGES + 1; k++) tick(acc);
        total_cnt++;
        if (got_q.size() !== 0) $display("FAIL fs_leak: got %0d want 0", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        bit acc;
        logic [XLEN-1:0] r0;
        clear_sb();
        ready_out = 1'b1;
        present(mk(3'd6, 1'b0, 32'h0000_1234, 32'h0001_0000, 60)); tick(acc);
        present(mk(3'd6, 1'b0, 32'h0000_4321, 32'h0002_0000, 61)); tick(acc);
        valid_in = 1'b0;
        ready_out = 1'b0;
        r0 = 32'h0001_1234;
        total_cnt++;
        if (valid_out !== 1'b1 || result !== r0) $display("FAIL mid_pre: got %b/%h want 1/%h", valid_out, result, r0); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt += 4;
        if (valid_out !== 1'b0) $display("FAIL mid_valid: got %b want 0", valid_out); else pass_cnt++;
        if (result !== '0) $display("FAIL mid_result: got %h want 0", result); else pass_cnt++;
        if (rob_entry !== '0) $display("FAIL mid_rob: got %0d want 0", rob_entry); else pass_cnt++;
        if (dest_tag !== '0) $display("FAIL mid_tag: got %0d want 0", dest_tag); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (ready_in !== 1'b1) $display("FAIL mid_ready_in: got %b want 1", ready_in); else pass_cnt++;
        clear_sb();
        @(posedge clk); cyc++; #1;
    endtask

`ifdef ARITH_FU_PERF_EN
    task automatic test_perf();
        bit acc;
        bit ok;
        int stalls_left;
        clear_sb();
        rst = 1'b0; #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) pend_q.push_back(rand_op(70 + i, i));
        stalls_left = 3;
        for (int k = 0; k < 100 && (pend_q.size() > 0 || stalls_left > 0); k++) begin
            if (pend_q.size() > 0) present(pend_q[0]); else valid_in = 1'b0;
            if (valid_out && stalls_left > 0) begin ready_out = 1'b0; stalls_left--; end
            else ready_out = 1'b1;
            tick(acc);
            if (acc) void'(pend_q.pop_front());
        end
        drain(ok);
        total_cnt += 2;
        if (perf_ops !== 32'd6) $display("FAIL perf_ops: got %0d want 6", perf_ops); else pass_cnt++;
        if (perf_stalls !== 32'd3) $display("FAIL perf_stalls: got %0d want 3", perf_stalls); else pass_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_random_bp();
        test_flush();
        test_flush_stall();
        test_reset_midstream();
`ifdef ARITH_FU_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
